// File: rtl/prog_mem_loader_pkg.sv
// Shared types and constants for the program-memory loader.
package prog_mem_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT,
        ST_HI,
        ST_LO,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/prog_mem_loader_timeout.sv
// Idle-cycle counter: cleared on activity, counts while enabled, flags when TIMEOUT is reached.
module loader_timeout #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    assign expired = (cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/prog_mem_loader.sv
// Framed byte stream -> 12-bit program-memory writes; holds the MCU in reset until an image loads.
// Optional trailing XOR checksum byte enabled with `define LOADER_CHECKSUM_EN.
module prog_mem_loader
    import prog_mem_loader_pkg::*;
#(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned DEPTH     = 10,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [DATA_W-1:0] pm_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    state_t            state;
    logic [ADDR_W:0]   nwords;
    logic [ADDR_W:0]   widx;
    logic [DATA_W-9:0] hi;
    logic              last_wr;
    logic              active;
    logic              is_sync;
    logic              tmo_expired;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign in_ready = 1'b1;
    assign is_sync  = (in_data == SYNC_BYTE);
    assign active   = (state == ST_CNT) || (state == ST_HI) ||
                      (state == ST_LO)  || (state == ST_CSUM);

    loader_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (in_valid || !active),
        .enable (active),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            nwords    <= '0;
            widx      <= '0;
            hi        <= '0;
            last_wr   <= 1'b0;
            pm_we     <= 1'b0;
            pm_addr   <= '0;
            pm_wdata  <= '0;
            cpu_rst   <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            pm_we <= 1'b0;
            // Final word without checksum: DONE is entered the cycle after its write strobe.
            if (last_wr) begin
                last_wr <= 1'b0;
                if (in_valid && is_sync) begin
                    state <= ST_CNT;
                    widx  <= '0;
                end else begin
                    state     <= ST_DONE;
                    load_done <= 1'b1;
                    cpu_rst   <= 1'b0;
                end
            end else if (active && tmo_expired) begin
                state    <= ST_ERR;
                load_err <= 1'b1;
            end else if (in_valid) begin
`ifdef LOADER_CHECKSUM_EN
                csum <= csum ^ in_data;
`endif
                case (state)
                    ST_IDLE, ST_DONE, ST_ERR: begin
                        if (is_sync) begin
                            state     <= ST_CNT;
                            cpu_rst   <= 1'b1;
                            load_done <= 1'b0;
                            load_err  <= 1'b0;
                            widx      <= '0;
`ifdef LOADER_CHECKSUM_EN
                            csum      <= '0;
`endif
                        end
                    end
                    ST_CNT: begin
                        nwords <= in_data[ADDR_W:0];
                        if (in_data > DEPTH_B) begin
                            state    <= ST_ERR;
                            load_err <= 1'b1;
                        end else if (in_data == 8'h00) begin
`ifdef LOADER_CHECKSUM_EN
                            state <= ST_CSUM;
`else
                            state     <= ST_DONE;
                            load_done <= 1'b1;
                            cpu_rst   <= 1'b0;
`endif
                        end else begin
                            state <= ST_HI;
                        end
                    end
                    ST_HI: begin
                        hi    <= in_data[DATA_W-9:0];
                        state <= ST_LO;
                    end
                    ST_LO: begin
                        pm_we    <= 1'b1;
                        pm_addr  <= widx[ADDR_W-1:0];
                        pm_wdata <= {hi, in_data};
                        widx     <= widx + 1'b1;
                        if ((widx + 1'b1) == nwords) begin
`ifdef LOADER_CHECKSUM_EN
                            state <= ST_CSUM;
`else
                            last_wr <= 1'b1;
`endif
                        end else begin
                            state <= ST_HI;
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    ST_CSUM: begin
                        if (in_data == csum) begin
                            state     <= ST_DONE;
                            load_done <= 1'b1;
                            cpu_rst   <= 1'b0;
                        end else begin
                            state    <= ST_ERR;
                            load_err <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule
